decode_stage: RTL and testbench

Registered instruction-decode stage for the pipelined RV32I/RV64I core. It sits between fetch and register read. It accepts a fetched instruction and PC over a valid/ready handshake and fully decodes it: control strobes, ALU op, register indices, sign-extended immediate and an illegal-instruction flag. The result is presented through a two-entry skid buffer, giving full throughput under downstream backpressure. Flush support allows branch redirects to discard in-flight instructions.

---
 rtl/decode_stage.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction decode behind a two-entry skid buffer with flush.
// Define DECODE_M_EXT_EN to accept the M-extension (funct7 = 0000001) encodings.
module decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic [XLEN-1:0] out_imm,
   output logic [3:0]      out_alu_op,
   output logic            out_reg_write,
   output logic            out_mem_write,
   output logic            out_mem_read,
   output logic            out_alu_src,
   output logic            out_mem_to_reg,
   output logic            out_branch,
   output logic            out_jump,
   output logic            out_jalr,
   output logic            out_lui,
   output logic            out_auipc,
   output logic            out_md,
   output logic            out_illegal
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1000;
   localparam logic [3:0] ALU_SLT   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;

`ifdef DECODE_M_EXT_EN
   localparam logic M_EXT = 1'b1;
`else
   localparam logic M_EXT = 1'b0;
`endif

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [XLEN-1:0] imm;
      logic [3:0]      alu_op;
      logic            reg_write;
      logic            mem_write;
      logic            mem_read;
      logic            alu_src;
      logic            mem_to_reg;
      logic            branch;
      logic            jump;
      logic            jalr;
      logic            lui;
      logic            auipc;
      logic            md;
      logic            illegal;
   } entry_t;

   typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

   state_t      state_q, state_d;
   entry_t      out_q, out_d, skid_q, skid_d, dec;
   logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic        accept, drain, illegal, shift_bad;
   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm32;

   // Combinational decode of the instruction currently offered by fetch.
   always_comb begin
      opcode     = in_instr[6:0];
      f3         = in_instr[14:12];
      f7         = in_instr[31:25];
      imm32      = 32'd0;
      illegal    = 1'b0;
      dec        = '0;
      dec.pc     = in_pc;
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.rd     = in_instr[11:7];
      dec.funct3 = f3;
      // RV64 shift amounts are six bits wide, so only instr[31:26] are the qualifier bits.
      if (XLEN == 64) begin
         shift_bad = (in_instr[31:26] != 6'b000000) &&
                     !((f3 == 3'b101) && (in_instr[31:26] == 6'b010000));
      end else begin
         shift_bad = (f7 != 7'b0000000) && !((f3 == 3'b101) && (f7 == 7'b0100000));
      end
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            if (f7 == 7'b0000000) begin
               dec.alu_op = {1'b0, f3};
            end else if ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) begin
               dec.alu_op = {1'b1, f3};
            end else if (M_EXT && (f7 == 7'b0000001)) begin
               dec.md     = 1'b1;
               dec.alu_op = ALU_ADD;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_IMM: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = {(f3 == 3'b101) & in_instr[30], f3};
            imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
            illegal       = ((f3 == 3'b001) || (f3 == 3'b101)) && shift_bad;
         end
         OP_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.mem_read   = 1'b1;
            dec.alu_src    = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.alu_op     = ALU_ADD;
            imm32          = {{20{in_instr[31]}}, in_instr[31:20]};
            illegal        = (f3 == 3'b111) ||
                             ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
         end
         OP_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = ALU_ADD;
            imm32         = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            illegal       = (XLEN == 64) ? (f3 > 3'b011) : (f3 > 3'b010);
         end
         OP_BRANCH: begin
            dec.branch = 1'b1;
            imm32      = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            illegal    = (f3[2:1] == 2'b01);
            case (f3[2:1])
               2'b10:   dec.alu_op = ALU_SLT;
               2'b11:   dec.alu_op = ALU_SLTU;
               default: dec.alu_op = ALU_SUB;
            endcase
         end
         OP_JAL: begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
            imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
         end
         OP_JALR: begin
            dec.jalr      = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            dec.alu_op    = ALU_ADD;
            imm32         = {{20{in_instr[31]}}, in_instr[31:20]};
            illegal       = (f3 != 3'b000);
         end
         OP_LUI: begin
            dec.lui       = 1'b1;
            dec.reg_write = 1'b1;
            imm32         = {in_instr[31:12], 12'h000};
         end
         OP_AUIPC: begin
            dec.auipc     = 1'b1;
            dec.reg_write = 1'b1;
            imm32         = {in_instr[31:12], 12'h000};
         end
         default: illegal = 1'b1;
      endcase
      dec.imm = XLEN'($signed(imm32));
      // Illegal entries still flow to carry their PC to the trap logic, but must not act.
      if (illegal) begin
         {dec.reg_write, dec.mem_write, dec.mem_read, dec.alu_src, dec.mem_to_reg,
          dec.branch, dec.jump, dec.jalr, dec.lui, dec.auipc, dec.md} = 11'b0;
      end else if (dec.rd == 5'd0) begin
         dec.reg_write = 1'b0;
      end else begin
         dec.reg_write = dec.reg_write;
      end
      dec.illegal = illegal;
   end

   // Skid-buffer next-state: output register plus one overflow entry, flush wins.
   always_comb begin
      accept  = in_valid & in_ready_q;
      drain   = out_valid_q & out_ready;
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d = S_ONE;
                  out_d   = dec;
               end else begin
                  state_d = S_EMPTY;
               end
            end
            S_ONE: begin
               if (accept && drain) begin
                  out_d = dec;
               end else if (accept) begin
                  state_d = S_TWO;
                  skid_d  = dec;
               end else if (drain) begin
                  state_d = S_EMPTY;
               end else begin
                  state_d = S_ONE;
               end
            end
            S_TWO: begin
               if (drain) begin
                  state_d = S_ONE;
                  out_d   = skid_q;
               end else begin
                  state_d = S_TWO;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
      out_valid_d = (state_d != S_EMPTY);
      in_ready_d  = (state_d != S_TWO);
   end

   // State and entry registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = out_valid_q;
   assign out_pc         = out_q.pc;
   assign out_rs1        = out_q.rs1;
   assign out_rs2        = out_q.rs2;
   assign out_rd         = out_q.rd;
   assign out_funct3     = out_q.funct3;
   assign out_imm        = out_q.imm;
   assign out_alu_op     = out_q.alu_op;
   assign out_reg_write  = out_q.reg_write;
   assign out_mem_write  = out_q.mem_write;
   assign out_mem_read   = out_q.mem_read;
   assign out_alu_src    = out_q.alu_src;
   assign out_mem_to_reg = out_q.mem_to_reg;
   assign out_branch     = out_q.branch;
   assign out_jump       = out_q.jump;
   assign out_jalr       = out_q.jalr;
   assign out_lui        = out_q.lui;
   assign out_auipc      = out_q.auipc;
   assign out_illegal    = out_q.illegal;
`ifdef DECODE_M_EXT_EN
   assign out_md         = out_q.md;
`else
   assign out_md         = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven scoreboard bench for decode_stage (XLEN = 32).
module tb_decode_stage;
   localparam logic [11:0] RW = 12'h800, MW = 12'h400, MR = 12'h200, AS = 12'h100;
   localparam logic [11:0] M2R = 12'h080, BR = 12'h040, JP = 12'h020, JR = 12'h010;
   localparam logic [11:0] LU = 12'h008, AU = 12'h004, MD = 12'h002, IL = 12'h001;
   localparam int NV = 24;

   typedef struct {
      logic [31:0] instr;
      logic [11:0] strb;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        chk_imm;
      logic        chk_alu;
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [31:0] pc;
   } sb_t;

   logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [2:0]  out_funct3;
   logic [3:0]  out_alu_op;
   logic        out_reg_write, out_mem_write, out_mem_read, out_alu_src, out_mem_to_reg;
   logic        out_branch, out_jump, out_jalr, out_lui, out_auipc, out_md, out_illegal;
   logic [11:0] act_strb;

   int   n_checks, n_errors, last_wait;
   bit   rand_ready;
   vec_t tbl[NV];
   sb_t  cur, e;
   sb_t  exp_q[$];

   decode_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
      .out_imm(out_imm), .out_alu_op(out_alu_op),
      .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
      .out_mem_read(out_mem_read), .out_alu_src(out_alu_src),
      .out_mem_to_reg(out_mem_to_reg), .out_branch(out_branch), .out_jump(out_jump),
      .out_jalr(out_jalr), .out_lui(out_lui), .out_auipc(out_auipc),
      .out_md(out_md), .out_illegal(out_illegal)
   );

   assign act_strb = {out_reg_write, out_mem_write, out_mem_read, out_alu_src, out_mem_to_reg,
                      out_branch, out_jump, out_jalr, out_lui, out_auipc, out_md, out_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [11:0] strb,
                               input logic [31:0] imm, input logic [3:0] alu,
                               input logic ci, input logic ca);
      vec_t v;
      v.instr = instr; v.strb = strb; v.imm = imm; v.alu = alu;
      v.chk_imm = ci;  v.chk_alu = ca;
      return v;
   endfunction

   // Scoreboard: push on accept, pop and compare on drain; flush and reset discard entries.
   always @(negedge clk) begin
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_output: got entry pc %h expected no entry", out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("pc", 64'(out_pc), 64'(e.pc));
               chk("reg_fields", 64'({out_rs1, out_rs2, out_rd, out_funct3}),
                   64'({e.v.instr[19:15], e.v.instr[24:20], e.v.instr[11:7], e.v.instr[14:12]}));
               chk("strobes", 64'(act_strb), 64'(e.v.strb));
               if (e.v.chk_imm) chk("imm", 64'(out_imm), 64'(e.v.imm));
               if (e.v.chk_alu) chk("alu_op", 64'(out_alu_op), 64'(e.v.alu));
            end
         end
         if (in_valid && in_ready) exp_q.push_back(cur);
      end
   end

   // Random backpressure for the soak phase.
   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Offer one table entry; called and returns at posedge+1.
   task automatic offer(input int idx, input logic [31:0] pc);
      int n;
      bit ok;
      in_instr = tbl[idx].instr;
      in_pc    = pc;
      cur.v    = tbl[idx];
      cur.pc   = pc;
      in_valid = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) chk("accept_timeout", 64'(0), 64'(1));
      in_valid  = 1'b0;
      last_wait = n - 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, n, gap;
      n_checks = 0; n_errors = 0; last_wait = 0; rand_ready = 1'b0;
      tbl[0]  = mk(32'h00500093, RW | AS,           32'h00000005, 4'b0000, 1'b1, 1'b1);
      tbl[1]  = mk(32'h402081B3, RW,                32'h00000000, 4'b1000, 1'b1, 1'b1);
      tbl[2]  = mk(32'hFFC12283, RW | MR | AS | M2R, 32'hFFFFFFFC, 4'b0000, 1'b1, 1'b1);
      tbl[3]  = mk(32'hFFFFFFFF, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[4]  = mk(32'h00000013, AS,                32'h00000000, 4'b0000, 1'b1, 1'b1);
`ifdef DECODE_M_EXT_EN
      tbl[5]  = mk(32'h022081B3, RW | MD,           32'h00000000, 4'b0000, 1'b1, 1'b1);
`else
      tbl[5]  = mk(32'h022081B3, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
`endif
      tbl[6]  = mk(32'h00512423, MW | AS,           32'h00000008, 4'b0000, 1'b1, 1'b1);
      tbl[7]  = mk(32'hFE208CE3, BR,                32'hFFFFFFF8, 4'b1000, 1'b1, 1'b1);
      tbl[8]  = mk(32'hFE20ECE3, BR,                32'hFFFFFFF8, 4'b0011, 1'b1, 1'b1);
      tbl[9]  = mk(32'h4030D213, RW | AS,           32'h00000403, 4'b1101, 1'b1, 1'b1);
      tbl[10] = mk(32'h40309213, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[11] = mk(32'h123453B7, RW | LU,           32'h12345000, 4'b0000, 1'b1, 1'b0);
      tbl[12] = mk(32'h010000EF, RW | JP,           32'h00000010, 4'b0000, 1'b1, 1'b0);
      tbl[13] = mk(32'h00008067, JR | AS,           32'h00000000, 4'b0000, 1'b1, 1'b1);
      tbl[14] = mk(32'h00009067, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[15] = mk(32'h00001117, RW | AU,           32'h00001000, 4'b0000, 1'b1, 1'b0);
      tbl[16] = mk(32'h0000F083, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[17] = mk(32'h00000000, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[18] = mk(32'h402091B3, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[19] = mk(32'h00513423, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[20] = mk(32'hFE20ACE3, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);
      tbl[21] = mk(32'h0020C1B3, RW,                32'h00000000, 4'b0100, 1'b1, 1'b1);
      tbl[22] = mk(32'hFFF12093, RW | AS,           32'hFFFFFFFF, 4'b0010, 1'b1, 1'b1);
      tbl[23] = mk(32'h0000B083, IL,                32'h00000000, 4'b0000, 1'b0, 1'b0);

      // Reset, with an instruction offered that must be ignored.
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h00000050;
      cur.v = tbl[0]; cur.pc = 32'h00000050;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ignores_input", 64'(out_valid), 64'(0));
      step();
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      chk("reset_pc_imm", {out_pc, out_imm}, 64'(0));
      chk("reset_fields", 64'({act_strb, out_alu_op, out_rs1, out_rs2, out_rd, out_funct3}), 64'(0));
      step();

      // Single addi: one-cycle latency.
      out_ready = 1'b1;
      offer(0, 32'h00000100);
      @(negedge clk);
      chk("latency_out_valid", 64'(out_valid), 64'(1));
      step();

      // sub then lw back to back: one per cycle.
      offer(1, 32'h00000104);
      chk("b2b_sub_wait", 64'(last_wait), 64'(0));
      offer(2, 32'h00000108);
      chk("b2b_lw_wait", 64'(last_wait), 64'(0));
      @(negedge clk);
      chk("b2b_lw_next_cycle", 64'({out_valid, out_pc}), 64'({1'b1, 32'h00000108}));
      step();

      // Backpressure: two accepted, third waits, order preserved.
      out_ready = 1'b0;
      offer(21, 32'h00000200);
      offer(22, 32'h00000204);
      @(negedge clk);
      chk("in_ready_low_in_two", 64'(in_ready), 64'(0));
      chk("stall_pc_0", 64'(out_pc), 64'(32'h00000200));
      step();
      @(negedge clk);
      chk("stall_stable", 64'({out_valid, out_pc, out_alu_op}), 64'({1'b1, 32'h00000200, 4'b0100}));
      step();
      out_ready = 1'b1;
      offer(9, 32'h00000208);
      chk("third_accept_wait", 64'(last_wait), 64'(1));
      repeat (3) step();

      // Flush in TWO while offering: nothing flushed may emerge.
      out_ready = 1'b0;
      offer(6, 32'h00000300);
      offer(7, 32'h00000304);
      in_instr = tbl[0].instr; in_pc = 32'h0000030C;
      cur.v = tbl[0]; cur.pc = 32'h0000030C;
      in_valid = 1'b1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'(0));
      chk("flush_in_ready", 64'(in_ready), 64'(1));
      out_ready = 1'b1;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      chk("flush_no_ghost", 64'(cnt), 64'(0));
      step();

      // Reset while full discards both entries.
      out_ready = 1'b0;
      offer(12, 32'h00000400);
      offer(11, 32'h00000404);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("midreset_out_valid", 64'(out_valid), 64'(0));
      chk("midreset_in_ready", 64'(in_ready), 64'(1));
      step();

      // Full table at full throughput.
      out_ready = 1'b1;
      for (int i = 0; i < NV; i++) offer(i, 32'h00001000 + 32'(4 * i));

      // Soak with random gaps and random backpressure.
      rand_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NV; i++) begin
            gap = int'($urandom_range(0, 2));
            repeat (gap) step();
            offer(i, 32'h00002000 + 32'(256 * r) + 32'(4 * i));
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
